note_scheduler: RTL and testbench
=================================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter INTERVAL, default 200: ticks between successive note-row spawns.
REQ-002 SHALL have parameter POS_MAX, default 520: last on-screen position before a slot is freed.
REQ-003 SHALL have parameter SONG_LEN, default 16: number of note rows in the song (1..16).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tick, input, 1 bit: one-cycle frame-advance strobe.
REQ-007 SHALL have port start, input, 1 bit: level; begins play from IDLE.
REQ-008 SHALL have port hold, input, 1 bit: level; freezes all motion and spawn timing.
REQ-009 SHALL have port abort, input, 1 bit: level; returns to IDLE and clears slots.
REQ-010 SHALL have port note_addr, output, 4 bits: song ROM row address.
REQ-011 SHALL have port note_data, input, 3 bits: ROM row, combinational on note_addr; bit2 red lane, bit1 green lane, bit0 blue lane.
REQ-012 SHALL have port pos_flat, output, 90 bits: slot s position in bits [10s+9:10s]; slots 0-2 red, 3-5 green, 6-8 blue.
REQ-013 SHALL have port active, output, 9 bits: slot occupied flags.
REQ-014 SHALL have port state_o, output, 3 bits: IDLE=001, PLAY=010, DRAIN=011, DONE=100.
REQ-015 SHALL have port drop_cnt, output, 8 bits: saturating count of notes dropped for lack of a free slot.
REQ-016 SHALL have port song_done, output, 1 bit: high iff state is DONE.

Function
REQ-017 SHALL act only on cycles where tick=1 and hold=0 ("step"), except start/abort transitions, which act on any cycle.
REQ-018 IDLE: start=1 -> PLAY next cycle; interval counter=0, note_addr=0.
REQ-019 PLAY step: each active slot with pos<POS_MAX SHALL increment pos by 1; an active slot with pos==POS_MAX SHALL clear to pos=0, active=0.
REQ-020 PLAY step with interval counter==0 SHALL spawn row note_data: for each set lane bit, the lowest-index slot of that lane inactive before this step gets active=1, pos=0.
REQ-021 A slot freed on the same step SHALL NOT be eligible for spawn; a spawned slot SHALL NOT advance on its spawn step.
REQ-022 Lane bit set with no eligible slot: note dropped; drop_cnt +1, saturating at 255; multiple lanes dropping on one step add their count.
REQ-023 Interval counter SHALL increment each step and wrap from INTERVAL-1 to 0.
REQ-024 After spawning row SONG_LEN-1, note_addr SHALL hold at SONG_LEN-1 and state -> DRAIN.
REQ-025 DRAIN step: advance/free as REQ-019, no spawns; once active==0, state -> DONE next cycle.
REQ-026 DONE: positions frozen at 0; start=1 -> IDLE with drop_cnt cleared.
REQ-027 abort=1 in any state SHALL force IDLE next cycle: all pos=0, active=0, note_addr=0, interval counter=0; drop_cnt retained. abort takes priority over start and tick.
REQ-028 hold=1 SHALL leave pos, active, counters, and state unchanged; tick during hold is discarded, not queued.
REQ-029 State, counters, and slots SHALL be registered; outputs SHALL be registers or direct decodes of them; no combinational path from tick to outputs.
REQ-030 Unused state encodings SHALL recover to IDLE on the next cycle.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, pos_flat=0, active=0, note_addr=0, interval counter=0, drop_cnt=0, song_done=0.
REQ-032 Release of reset_n SHALL be recognised on the next rising clk edge; no step occurs on that edge.

Verification
REQ-033 Reset, start, ROM row0=100, 1 step -> active=000000001, pos0=0; 10 more steps -> pos0=10.
REQ-034 Single red note, 521 steps after spawn -> active[0]=0, pos0=0, no drop.
REQ-035 INTERVAL=1, all rows 111, 4 steps -> all 9 slots active, drop_cnt=3; 4th row dropped on all lanes.
REQ-036 Slot at pos=POS_MAX with spawn due on the same step in a full lane -> slot freed, note dropped, drop_cnt +1.
REQ-037 hold=1 across 50 ticks mid-PLAY -> pos_flat, note_addr, interval counter unchanged; release and resume exact.
REQ-038 abort during DRAIN -> IDLE next cycle, active=0, drop_cnt retained; full 16-row song run -> DONE, song_done=1.

Source files
------------

// File: rtl/note_scheduler.sv
// ---------------------------------------------------------------------------
// note_scheduler
//
// Rhythm-game note spawner. Walks a small song ROM one row per INTERVAL
// frame steps and drops each row's notes into per-lane position slots
// (three lanes: red, green, blue; three slots per lane). Every occupied
// slot advances one position per frame step until it reaches POS_MAX,
// at which point it is freed. Once the last row has been issued the
// block drains the remaining notes and then reports DONE.
//
// A "step" is a cycle with tick=1 and hold=0. start and abort act on
// any cycle; abort beats everything else.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   tick       one-cycle frame-advance strobe
//   start      IDLE -> PLAY, and DONE -> IDLE (clears drop_cnt)
//   hold       freezes motion and spawn timing while high
//   abort      forces IDLE and empties every slot (drop_cnt kept)
//   note_addr  song ROM row address
//   note_data  ROM row, combinational on note_addr {red, green, blue}
//   pos_flat   slot s position at [10s+9:10s]; 0-2 red, 3-5 green, 6-8 blue
//   active     slot occupied flags
//   state_o    IDLE=001 PLAY=010 DRAIN=011 DONE=100
//   drop_cnt   saturating count of notes lost for lack of a free slot
//   song_done  high while in DONE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// note_slot: one on-screen note position.
//
//   clr_i    empty the slot (abort / illegal-state recovery)
//   step_i   frame step while the song is moving
//   spawn_i  occupy the slot at position 0 (only raised for an empty slot)
//   pos_o    current position
//   active_o slot is occupied
// ---------------------------------------------------------------------------
module note_slot #(
    parameter int POS_MAX = 520
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       step_i,
    input  logic       spawn_i,
    output logic [9:0] pos_o,
    output logic       active_o
);

    logic [9:0] pos_q, pos_d;
    logic       act_q, act_d;

    always_comb begin
        pos_d = pos_q;
        act_d = act_q;
        if (clr_i) begin
            pos_d = '0;
            act_d = 1'b0;
        end else if (spawn_i) begin
            // A freshly spawned note sits at 0 for its spawn step.
            pos_d = '0;
            act_d = 1'b1;
        end else if (step_i && act_q) begin
            if (pos_q == 10'(POS_MAX)) begin
                pos_d = '0;
                act_d = 1'b0;
            end else begin
                pos_d = pos_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= '0;
            act_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            act_q <= act_d;
        end
    end

    assign pos_o    = pos_q;
    assign active_o = act_q;

endmodule

// ---------------------------------------------------------------------------
// note_scheduler top
// ---------------------------------------------------------------------------
module note_scheduler #(
    parameter int INTERVAL = 200,
    parameter int POS_MAX  = 520,
    parameter int SONG_LEN = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start,
    input  logic        hold,
    input  logic        abort,
    output logic [3:0]  note_addr,
    input  logic [2:0]  note_data,
    output logic [89:0] pos_flat,
    output logic [8:0]  active,
    output logic [2:0]  state_o,
    output logic [7:0]  drop_cnt,
    output logic        song_done
);

    localparam int NUM_LANES = 3;
    localparam int LANE_SLOTS = 3;
    localparam int NUM_SLOTS = NUM_LANES * LANE_SLOTS;
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [3:0]    LAST_ROW = 4'(SONG_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_PLAY  = 3'b010,
        S_DRAIN = 3'b011,
        S_DONE  = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    drop_q, drop_d;

    logic                 step;
    logic                 spawn_due;
    logic                 slot_clr;
    logic                 slot_step;
    logic [NUM_SLOTS-1:0] spawn_vec;
    logic [NUM_SLOTS-1:0] act_vec;
    logic [1:0]           drop_n;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_sat;

    assign step      = tick & ~hold;
    assign spawn_due = step & ~abort & (state_q == S_PLAY) & (cnt_q == '0);

    // Spawn target per lane: lowest slot that was empty before this step.
    // Slots freed on this same step still read as occupied here, so they
    // cannot be reused until the following step.
    always_comb begin
        spawn_vec = '0;
        drop_n    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (spawn_due && note_data[NUM_LANES-1-l]) begin
                if (!act_vec[LANE_SLOTS*l])
                    spawn_vec[LANE_SLOTS*l] = 1'b1;
                else if (!act_vec[LANE_SLOTS*l+1])
                    spawn_vec[LANE_SLOTS*l+1] = 1'b1;
                else if (!act_vec[LANE_SLOTS*l+2])
                    spawn_vec[LANE_SLOTS*l+2] = 1'b1;
                else
                    drop_n = drop_n + 2'd1;
            end
        end
    end

    assign drop_sum = {1'b0, drop_q} + {7'b0, drop_n};
    assign drop_sat = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Next-state / control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        slot_clr  = 1'b0;
        slot_step = 1'b0;
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            addr_d   = '0;
            slot_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                        addr_d  = '0;
                    end
                end
                S_PLAY: begin
                    if (step) begin
                        slot_step = 1'b1;
                        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
                        if (cnt_q == '0) begin
                            drop_d = drop_sat;
                            // Address parks on the last row once issued.
                            if (addr_q == LAST_ROW)
                                state_d = S_DRAIN;
                            else
                                addr_d = addr_q + 4'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    slot_step = step;
                    if (!hold && (act_vec == '0))
                        state_d = S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_IDLE;
                        drop_d  = '0;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a clean IDLE.
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    addr_d   = '0;
                    slot_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    // Slot array
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        note_slot #(
            .POS_MAX (POS_MAX)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr_i    (slot_clr),
            .step_i   (slot_step),
            .spawn_i  (spawn_vec[s]),
            .pos_o    (pos_flat[10*s +: 10]),
            .active_o (act_vec[s])
        );
    end

    assign active    = act_vec;
    assign note_addr = addr_q;
    assign state_o   = state_q;
    assign drop_cnt  = drop_q;
    assign song_done = (state_q == S_DONE);

endmodule

// File: tb/tb_note_scheduler.sv
// ---------------------------------------------------------------------------
// tb_note_scheduler
//
// Two scheduler instances share clock, tick, hold and abort:
//   u_a : default parameters (INTERVAL=200, POS_MAX=520, SONG_LEN=16)
//   u_b : INTERVAL=1, POS_MAX=6 so lane saturation and slot recycling
//         happen within a handful of steps.
// Only one instance is out of IDLE at a time; the other ignores tick.
// ---------------------------------------------------------------------------
module tb_note_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, tick, hold, abort, start_a, start_b;
    logic [3:0]  addr_a, addr_b;
    logic [2:0]  nd_a, nd_b;
    logic [89:0] pos_a, pos_b;
    logic [8:0]  act_a, act_b;
    logic [2:0]  st_a, st_b;
    logic [7:0]  drop_a, drop_b;
    logic        done_a, done_b;

    logic [2:0] rom_a [16];
    logic [2:0] rom_b [16];
    assign nd_a = rom_a[addr_a];
    assign nd_b = rom_b[addr_b];

    int n_chk  = 0;
    int n_fail = 0;

    note_scheduler u_a (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start_a),
        .hold(hold), .abort(abort), .note_addr(addr_a), .note_data(nd_a),
        .pos_flat(pos_a), .active(act_a), .state_o(st_a),
        .drop_cnt(drop_a), .song_done(done_a)
    );

    note_scheduler #(.INTERVAL(1), .POS_MAX(6), .SONG_LEN(16)) u_b (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start_b),
        .hold(hold), .abort(abort), .note_addr(addr_b), .note_data(nd_b),
        .pos_flat(pos_b), .active(act_b), .state_o(st_b),
        .drop_cnt(drop_b), .song_done(done_b)
    );

    task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // n consecutive step cycles; returns on the negedge after the last one.
    task automatic steps(input int n);
        @(negedge clk) tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        hold    = 1'b0;
        abort   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = 3'b000;
            rom_b[i] = 3'b111;
        end
        rom_a[0] = 3'b100;

        // ---- reset ----
        repeat (2) @(negedge clk);
        chk("rst_state", st_a, 3'b001);
        chk("rst_pos",   pos_a, 90'd0);
        chk("rst_act",   act_a, 9'd0);
        chk("rst_addr",  addr_a, 4'd0);
        chk("rst_drop",  drop_a, 8'd0);
        chk("rst_done",  done_a, 1'b0);
        reset_n = 1'b1;

        // ---- instance A: default parameters ----
        pulse_start_a();
        chk("a_play", st_a, 3'b010);
        steps(1);
        chk("a_spawn_act", act_a, 9'b000000001);
        chk("a_spawn_pos", pos_a[9:0], 10'd0);
        chk("a_addr1", addr_a, 4'd1);
        steps(10);
        chk("a_pos10", pos_a[9:0], 10'd10);

        // hold: 50 ticks discarded
        hold = 1'b1;
        steps(50);
        chk("a_hold_pos",   pos_a, 90'd10);
        chk("a_hold_addr",  addr_a, 4'd1);
        chk("a_hold_state", st_a, 3'b010);
        hold = 1'b0;

        // step 200: next row not yet due; step 201: row 1 issued
        steps(189);
        chk("a_s200_addr", addr_a, 4'd1);
        chk("a_s200_pos",  pos_a[9:0], 10'd199);
        steps(1);
        chk("a_s201_addr", addr_a, 4'd2);
        chk("a_s201_pos",  pos_a[9:0], 10'd200);

        // reach POS_MAX, then free on the next step
        steps(320);
        chk("a_posmax",     pos_a[9:0], 10'd520);
        chk("a_posmax_act", act_a, 9'b000000001);
        steps(1);
        chk("a_freed_act",  act_a, 9'd0);
        chk("a_freed_pos",  pos_a[9:0], 10'd0);
        chk("a_freed_drop", drop_a, 8'd0);
        chk("a_freed_addr", addr_a, 4'd3);

        pulse_abort();
        chk("a_abort_state", st_a, 3'b001);
        chk("a_abort_addr",  addr_a, 4'd0);

        // ---- instance B: INTERVAL=1, POS_MAX=6, all rows 111 ----
        pulse_start_b();
        chk("b_play", st_b, 3'b010);
        steps(4);
        chk("b4_act",   act_b, 9'h1FF);
        chk("b4_drop",  drop_b, 8'd3);
        chk("b4_pos0",  pos_b[9:0], 10'd3);
        chk("b4_pos8",  pos_b[89:80], 10'd1);
        chk("b4_addr",  addr_b, 4'd4);

        // step 8: head slots at POS_MAX freed while their lanes stay full
        steps(4);
        chk("b8_act",  act_b, 9'b110110110);
        chk("b8_drop", drop_b, 8'd15);
        chk("b8_pos0", pos_b[9:0], 10'd0);
        steps(1);
        chk("b9_act",  act_b, 9'b101101101);
        chk("b9_drop", drop_b, 8'd15);
        chk("b9_pos2", pos_b[29:20], 10'd6);
        steps(1);
        chk("b10_act", act_b, 9'b011011011);

        steps(6);
        chk("b16_state", st_b, 3'b011);
        chk("b16_drop",  drop_b, 8'd30);
        chk("b16_addr",  addr_b, 4'd15);
        chk("b16_act",   act_b, 9'b110110110);

        // abort during DRAIN
        pulse_abort();
        chk("b_abort_state", st_b, 3'b001);
        chk("b_abort_act",   act_b, 9'd0);
        chk("b_abort_pos",   pos_b, 90'd0);
        chk("b_abort_drop",  drop_b, 8'd30);
        chk("b_abort_addr",  addr_b, 4'd0);

        // ---- instance B: full song run to DONE ----
        for (int i = 0; i < 16; i++) rom_b[i] = 3'b000;
        rom_b[0]  = 3'b001;
        rom_b[14] = 3'b100;
        pulse_start_b();
        steps(7);
        chk("r7_act",  act_b, 9'b001000000);
        chk("r7_pos6", pos_b[69:60], 10'd6);
        steps(1);
        chk("r8_act",  act_b, 9'd0);
        steps(8);
        chk("r16_state", st_b, 3'b011);
        chk("r16_act",   act_b, 9'b000000001);
        chk("r16_pos0",  pos_b[9:0], 10'd1);
        chk("r16_addr",  addr_b, 4'd15);
        steps(5);
        chk("r21_pos0",  pos_b[9:0], 10'd6);
        chk("r21_state", st_b, 3'b011);
        steps(1);
        chk("r22_act",   act_b, 9'd0);
        chk("r22_state", st_b, 3'b011);
        @(negedge clk);
        chk("done_state", st_b, 3'b100);
        chk("done_flag",  done_b, 1'b1);
        chk("done_pos",   pos_b, 90'd0);
        chk("done_drop",  drop_b, 8'd30);
        pulse_start_b();
        chk("restart_state", st_b, 3'b001);
        chk("restart_drop",  drop_b, 8'd0);
        chk("restart_done",  done_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
